// File: rtl/sipo_frame_ctrl.sv
// ---------------------------------------------------------------------------
// sipo_frame_ctrl
//
// Frames a serial bit stream into WIDTH-bit words. A one-cycle sof pulse
// starts (or restarts) a frame. Each cycle with din_vld=1 shifts one bit in,
// MSB first. When the last bit arrives, the assembled word is latched into
// the output register. It is then offered to a consumer through a
// valid/ready handshake.
//
// Optional feature, macro SIPO_FRAME_PARITY_EN:
//   When it is defined, one even-parity bit follows the data bits.
//   par_err reports ^{word, parity_bit} for the word held in dout.
//   When it is undefined, no parity state exists and par_err is tied to 0.
//
// Handshake: dout_valid=1 means dout holds an unconsumed word. The consumer
// takes the word on a rising edge where dout_valid & dout_ready. While
// dout_valid=1 and dout_ready=0, dout and dout_valid do not change.
//
// Ports:
//   clk        in   system clock, rising edge
//   clear      in   asynchronous active-high reset
//   sof        in   start-of-frame pulse
//   din        in   serial data bit, sampled when din_vld=1
//   din_vld    in   bit strobe
//   dout       out  assembled word, first bit received in dout[WIDTH-1]
//   dout_valid out  dout holds an unconsumed word
//   dout_ready in   consumer accepts dout
//   busy       out  frame in progress (SHIFT or PARITY)
//   overrun    out  sticky: a completed word was dropped
//   par_err    out  parity error of the word in dout
// ---------------------------------------------------------------------------
module sipo_frame_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             sof,
    input  logic             din,
    input  logic             din_vld,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             par_err
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef SIPO_FRAME_PARITY_EN
        ,PARITY = 2'd2
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overrun_q, overrun_d;

    logic             complete;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;

`ifdef SIPO_FRAME_PARITY_EN
    logic par_err_q, par_err_d;
    logic par_bit;
`endif

    assign shifted = {shreg_q[WIDTH-2:0], din};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef SIPO_FRAME_PARITY_EN
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic: framing and bit counting
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        complete  = 1'b0;
        word      = shifted;
`ifdef SIPO_FRAME_PARITY_EN
        par_bit   = 1'b0;
`endif

        if (sof) begin
            // sof in any state starts a new frame and drops partial bits.
            // A strobe in the same cycle becomes bit 0 of the new frame.
            state_d   = SHIFT;
            bit_cnt_d = '0;
            if (din_vld) begin
                shreg_d   = shifted;
                bit_cnt_d = CNT_W'(1);
            end
        end else begin
            case (state_q)
                IDLE: begin
                    // Strobes outside a frame are ignored.
                end
                SHIFT: begin
                    if (din_vld) begin
                        shreg_d = shifted;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
`ifdef SIPO_FRAME_PARITY_EN
                            state_d   = PARITY;
`else
                            state_d   = IDLE;
                            complete  = 1'b1;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
`ifdef SIPO_FRAME_PARITY_EN
                PARITY: begin
                    // The data word already sits in shreg. This strobe
                    // carries the parity bit only.
                    if (din_vld) begin
                        state_d  = IDLE;
                        complete = 1'b1;
                        word     = shreg_q;
                        par_bit  = ^{shreg_q, din};
                    end
                end
`endif
                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output register and handshake
    // ------------------------------------------------------------------
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;
`ifdef SIPO_FRAME_PARITY_EN
        par_err_d    = par_err_q;
`endif

        if (complete) begin
            // The slot is free when it is empty, or when the word it holds
            // is consumed on this same edge.
            if (!dout_valid_q || dout_ready) begin
                dout_d       = word;
                dout_valid_d = 1'b1;
`ifdef SIPO_FRAME_PARITY_EN
                par_err_d    = par_bit;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);
`ifdef SIPO_FRAME_PARITY_EN
    assign par_err    = par_err_q;
`else
    assign par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
module tb_sipo_frame_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;
`ifdef SIPO_FRAME_PARITY_EN
  localparam int TOTAL = WIDTH + 1;
`else
  localparam int TOTAL = WIDTH;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clear;
  logic sof, din, din_vld, dout_ready;
  logic [WIDTH-1:0] dout;
  logic dout_valid, busy, overrun, par_err;

  always #5 clk = ~clk;

  sipo_frame_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .clear      (clear),
    .sof        (sof),
    .din        (din),
    .din_vld    (din_vld),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .overrun    (overrun),
    .par_err    (par_err)
  );

  // ---------------- reference model ----------------
  bit               frame_q[$];
  bit               in_frame;
  logic [WIDTH-1:0] m_dout;
  bit               m_valid;
  bit               m_ovr;
  bit               m_par;
  logic [WIDTH-1:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    in_frame = 1'b0;
    m_dout   = '0;
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
    m_par    = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_update(input bit s, input bit d, input bit v, input bit r);
    bit               done;
    logic [WIDTH-1:0] w;
    bit               p;
    done = 1'b0;
    w    = '0;
    p    = 1'b0;
    if (s) begin
      in_frame = 1'b1;
      frame_q.delete();
      if (v) frame_q.push_back(d);
    end else if (in_frame && v) begin
      frame_q.push_back(d);
    end
    if (frame_q.size() == TOTAL) begin
      done = 1'b1;
      for (int i = 0; i < WIDTH; i++) w[WIDTH-1-i] = frame_q[i];
`ifdef SIPO_FRAME_PARITY_EN
      for (int i = 0; i < TOTAL; i++) p = p ^ frame_q[i];
`endif
      frame_q.delete();
      in_frame = 1'b0;
    end
    if (done) begin
      if (!m_valid || r) begin
        m_dout  = w;
        m_valid = 1'b1;
        m_par   = p;
        exp_q.push_back(w);
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("dout",       dout,       m_dout);
    check("dout_valid", dout_valid, m_valid);
    check("busy",       busy,       in_frame);
    check("overrun",    overrun,    m_ovr);
    check("par_err",    par_err,    m_par);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit s, input bit d, input bit v, input bit r);
    sof = s; din = d; din_vld = v; dout_ready = r;
    // Consumer side: a word taken on this edge must match the oldest expected word.
    if (dout_valid && r) begin
      if (exp_q.size() == 0) check("sb_empty", 1, 0);
      else check("sb_word", dout, exp_q.pop_front());
    end
    @(posedge clk);
    model_update(s, d, v, r);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, r);
  endtask

  // Sends n bits of seq (MSB first); first bit rides on sof. dout_ready is
  // raised only on the final strobe.
  task automatic send_bits(input logic [15:0] seq, input int n, input int gap, input bit rdy_last);
    for (int i = 0; i < n; i++) begin
      step(i == 0, seq[n-1-i], 1'b1, (i == n-1) ? rdy_last : 1'b0);
      if (i != n-1) idle(gap, 1'b0);
    end
  endtask

  // Sends a data word plus, in parity builds, a correct even-parity bit.
  task automatic send_frame(input logic [WIDTH-1:0] w, input int gap, input bit rdy_last);
`ifdef SIPO_FRAME_PARITY_EN
    send_bits({w, ^w}, TOTAL, gap, rdy_last);
`else
    send_bits(16'(w), TOTAL, gap, rdy_last);
`endif
  endtask

  task automatic apply_clear();
    clear = 1'b1;
    #1;
    model_reset();
    compare_all();
    #4;
    clear = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear = 1'b1; sof = 1'b0; din = 1'b0; din_vld = 1'b0; dout_ready = 1'b0;
    model_reset();
    #2;
    compare_all();
    #11;
    clear = 1'b0;

    // Reset mid-frame, then a clean frame.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t1_busy_mid", busy, 1'b1);
    apply_clear();
    check("t1_dout_clr", dout, 4'b0000);
    check("t1_busy_clr", busy, 1'b0);
    send_frame(4'b1011, 0, 1'b0);
    check("t1_dout", dout, 4'b1011);

    // Back-to-back result held, then drained.
    check("t2_valid", dout_valid, 1'b1);
    check("t2_busy", busy, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t2_drain", dout_valid, 1'b0);
    check("t2_hold", dout, 4'b1011);

    // Gapped strobes, then a mid-frame restart.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b0);
    send_frame(4'b1111, 2, 1'b0);
    check("t3_dout", dout, 4'b1111);
    check("t3_ovr", overrun, 1'b0);

    // Overrun with the consumer stalled.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(4'b1010, 0, 1'b0);
    send_frame(4'b0101, 0, 1'b0);
    check("t4_dout", dout, 4'b1010);
    check("t4_ovr", overrun, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t4_ovr_sticky", overrun, 1'b1);
    apply_clear();
    check("t4_ovr_clr", overrun, 1'b0);

    // Accept and complete on the same edge.
    send_frame(4'b1010, 0, 1'b0);
    send_frame(4'b0011, 0, 1'b1);
    check("t5_dout", dout, 4'b0011);
    check("t5_valid", dout_valid, 1'b1);
    check("t5_ovr", overrun, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SIPO_FRAME_PARITY_EN
    // Parity good and bad; valid rises only on the parity-bit edge.
    send_bits(16'b10111, 4, 0, 1'b0);
    check("t6_valid_pre", dout_valid, 1'b0);
    check("t6_busy_pre", busy, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("t6_valid", dout_valid, 1'b1);
    check("t6_par_ok", par_err, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(16'b10110, 5, 0, 1'b0);
    check("t6_dout", dout, 4'b1011);
    check("t6_par_bad", par_err, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 499) apply_clear();
      step($urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
